// File: rtl/vga_pkg.sv
// Shared definitions for the VGA sprite mover: active-area defaults, FSM states, directions.
package vga_pkg;

    localparam int unsigned H_ACTIVE_DEFAULT = 640;
    localparam int unsigned V_ACTIVE_DEFAULT = 480;
    localparam int unsigned POS_W            = 10;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        STEP_X = 2'd1,
        STEP_Y = 2'd2,
        COMMIT = 2'd3
    } state_e;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_e;

endpackage

// File: rtl/vga_axis_step.sv
// Combinational single-axis step: advance by spd, clamp at 0/max, flip direction on contact.
module vga_axis_step
    import vga_pkg::*;
(
    input  logic [POS_W-1:0] p_i,
    input  dir_e             dir_i,
    input  logic [3:0]       spd_i,
    input  logic [POS_W-1:0] max_i,
    output logic [POS_W-1:0] p_o,
    output dir_e             dir_o,
    output logic             bounce_o
);

    logic signed [POS_W:0] c;

    always_comb begin
        p_o      = p_i;
        dir_o    = dir_i;
        bounce_o = 1'b0;
        c        = '0;
        if (spd_i != '0) begin
            if (dir_i == DIR_POS) begin
                c = signed'({1'b0, p_i}) + signed'({7'b0, spd_i});
                if (c >= signed'({1'b0, max_i})) begin
                    p_o      = max_i;
                    dir_o    = DIR_NEG;
                    bounce_o = 1'b1;
                end else begin
                    p_o = c[POS_W-1:0];
                end
            end else begin
                c = signed'({1'b0, p_i}) - signed'({7'b0, spd_i});
                if (c <= 11'sd0) begin
                    p_o      = '0;
                    dir_o    = DIR_POS;
                    bounce_o = 1'b1;
                end else begin
                    p_o = c[POS_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/vga_sprite_mover.sv
// Per-frame box position update triggered by the vSync falling edge.
// Build option VGA_MOVER_BTN_EN adds button steering (btnL/btnR/btnU/btnD).
module vga_sprite_mover
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEFAULT,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEFAULT,
    parameter int unsigned BOX_W    = 16,
    parameter int unsigned BOX_H    = 16,
    parameter int unsigned X_INIT   = 200,
    parameter int unsigned Y_INIT   = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vSync,
    input  logic             hold,
    input  logic [3:0]       speed,
`ifdef VGA_MOVER_BTN_EN
    input  logic             btnL,
    input  logic             btnR,
    input  logic             btnU,
    input  logic             btnD,
`endif
    output logic [POS_W-1:0] x,
    output logic [POS_W-1:0] y,
    output logic             frameTick,
    output logic             bounceX,
    output logic             bounceY
);

    localparam logic [POS_W-1:0] XMAX = POS_W'(H_ACTIVE - BOX_W);
    localparam logic [POS_W-1:0] YMAX = POS_W'(V_ACTIVE - BOX_H);

    state_e           state_q, state_d;
    logic             vsync_q;
    logic [POS_W-1:0] x_q, y_q, nx_q, ny_q;
    dir_e             dirx_q, diry_q, ndirx_q, ndiry_q;
    logic [3:0]       spd_q;
    logic             bx_q, by_q, bncx_q, bncy_q;

    logic             sel_y;
    logic [POS_W-1:0] ax_p, ax_max, st_p;
    dir_e             ax_dir, st_dir_in, st_dir, res_dir;
    logic [3:0]       ax_spd, st_spd_in;
    logic             st_b, res_b;

`ifdef VGA_MOVER_BTN_EN
    logic [3:0] btn_q, btn_cur;
    logic       btn_any, btn_pos, btn_neg;

    assign btn_cur = (state_q == STEP_X) ? {btnD, btnU, btnR, btnL} : btn_q;
    assign btn_any = |btn_cur;
    assign btn_pos = sel_y ? btn_cur[3] : btn_cur[1];
    assign btn_neg = sel_y ? btn_cur[2] : btn_cur[0];
`endif

    // One stepper serves both axes: x in STEP_X (live speed), y in STEP_Y (latched speed).
    assign sel_y  = (state_q == STEP_Y);
    assign ax_p   = sel_y ? y_q    : x_q;
    assign ax_dir = sel_y ? diry_q : dirx_q;
    assign ax_spd = sel_y ? spd_q  : speed;
    assign ax_max = sel_y ? YMAX   : XMAX;

    always_comb begin
        st_dir_in = ax_dir;
        st_spd_in = ax_spd;
`ifdef VGA_MOVER_BTN_EN
        if (btn_any) begin
            if (btn_pos ^ btn_neg) st_dir_in = btn_pos ? DIR_POS : DIR_NEG;
            else                   st_spd_in = '0;
        end
`endif
    end

    vga_axis_step u_step (
        .p_i     (ax_p),
        .dir_i   (st_dir_in),
        .spd_i   (st_spd_in),
        .max_i   (ax_max),
        .p_o     (st_p),
        .dir_o   (st_dir),
        .bounce_o(st_b)
    );

    always_comb begin
        res_dir = st_dir;
        res_b   = st_b;
`ifdef VGA_MOVER_BTN_EN
        // Steered axes clamp without flipping the stored bounce direction.
        if (btn_any) begin
            res_dir = ax_dir;
            res_b   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= WAIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT:    if (!vSync && vsync_q) state_d = STEP_X;
            STEP_X:  state_d = STEP_Y;
            STEP_Y:  state_d = COMMIT;
            COMMIT:  state_d = WAIT;
            default: state_d = WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b1;
            x_q     <= POS_W'(X_INIT);
            y_q     <= POS_W'(Y_INIT);
            dirx_q  <= DIR_POS;
            diry_q  <= DIR_POS;
            nx_q    <= '0;
            ny_q    <= '0;
            ndirx_q <= DIR_POS;
            ndiry_q <= DIR_POS;
            spd_q   <= '0;
            bx_q    <= 1'b0;
            by_q    <= 1'b0;
            bncx_q  <= 1'b0;
            bncy_q  <= 1'b0;
`ifdef VGA_MOVER_BTN_EN
            btn_q   <= '0;
`endif
        end else begin
            vsync_q <= vSync;
            bncx_q  <= (state_q == COMMIT) && !hold && bx_q;
            bncy_q  <= (state_q == COMMIT) && !hold && by_q;
            case (state_q)
                STEP_X: begin
                    spd_q   <= speed;
                    nx_q    <= st_p;
                    ndirx_q <= res_dir;
                    bx_q    <= res_b;
`ifdef VGA_MOVER_BTN_EN
                    btn_q   <= {btnD, btnU, btnR, btnL};
`endif
                end
                STEP_Y: begin
                    ny_q    <= st_p;
                    ndiry_q <= res_dir;
                    by_q    <= res_b;
                end
                COMMIT: begin
                    if (!hold) begin
                        x_q    <= nx_q;
                        y_q    <= ny_q;
                        dirx_q <= ndirx_q;
                        diry_q <= ndiry_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        frameTick = (state_q == STEP_X);
        x         = x_q;
        y         = y_q;
        bounceX   = bncx_q;
        bounceY   = bncy_q;
    end

endmodule

// File: tb/tb_vga_sprite_mover.sv
// Randomized bench for vga_sprite_mover with a frame-level reference model and directed literal checks.
module tb_vga_sprite_mover;

    logic       clk = 1'b0;
    logic       rst, vSync, hold;
    logic [3:0] speed;
    logic [9:0] x, y;
    logic       frameTick, bounceX, bounceY;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    vga_sprite_mover dut (
        .clk      (clk),
        .rst      (rst),
        .vSync    (vSync),
        .hold     (hold),
        .speed    (speed),
        .x        (x),
        .y        (y),
        .frameTick(frameTick),
        .bounceX  (bounceX),
        .bounceY  (bounceY)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: one axis move as plain integer arithmetic.
    function automatic void mstep(input int p, input bit neg, input int s, input int mx,
                                  output int np, output bit nneg, output bit b);
        np = p; nneg = neg; b = 1'b0;
        if (s != 0) begin
            if (!neg) begin
                if (p + s >= mx) begin np = mx; nneg = 1'b1; b = 1'b1; end
                else np = p + s;
            end else begin
                if (p - s <= 0) begin np = 0; nneg = 1'b0; b = 1'b1; end
                else np = p - s;
            end
        end
    endfunction

    // Model: t counts cycles since the detected frame edge (0 = idle).
    int ex, ey, mspd, t;
    bit negx, negy, ebx, eby, prevv;

    always @(posedge clk) begin : model
        int nx, ny;
        bit nnx, nny, bx, by;
        mstep(ex, negx, mspd, 624, nx, nnx, bx);
        mstep(ey, negy, mspd, 464, ny, nny, by);
        if (rst) begin
            ex <= 200; ey <= 200; negx <= 1'b0; negy <= 1'b0;
            ebx <= 1'b0; eby <= 1'b0; t <= 0; prevv <= 1'b1; mspd <= 0;
        end else begin
            prevv <= vSync;
            ebx   <= 1'b0;
            eby   <= 1'b0;
            case (t)
                0: if (!vSync && prevv) t <= 1;
                1: begin mspd <= int'(speed); t <= 2; end
                2: t <= 3;
                default: begin
                    t <= 0;
                    if (!hold) begin
                        ex <= nx; ey <= ny; negx <= nnx; negy <= nny;
                        ebx <= bx; eby <= by;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("x", 32'(x), 32'(ex));
            chk("y", 32'(y), 32'(ey));
            chk("frameTick", 32'(frameTick), 32'(t == 1));
            chk("bounceX", 32'(bounceX), 32'(ebx));
            chk("bounceY", 32'(bounceY), 32'(eby));
        end
    end

    bit sbx, sby, sft;

    task automatic frame(input int s);
        @(negedge clk);
        speed = 4'(s);
        vSync = 1'b0;
        sbx = 1'b0; sby = 1'b0; sft = 1'b0;
        repeat (6) begin
            @(negedge clk);
            sbx |= bounceX; sby |= bounceY; sft |= frameTick;
        end
        vSync = 1'b1;
        repeat (2) begin
            @(negedge clk);
            sbx |= bounceX; sby |= bounceY; sft |= frameTick;
        end
    endtask

    initial begin
        int cnt;
        rst = 1'b1; vSync = 1'b1; hold = 1'b0; speed = 4'd5;
        @(posedge clk);
        started = 1'b1;
        @(negedge clk) vSync = 1'b0;
        @(negedge clk) vSync = 1'b1;
        chk("rst_x", 32'(x), 32'd200);
        chk("rst_y", 32'(y), 32'd200);
        chk("rst_ft", 32'(frameTick), 32'd0);
        @(negedge clk) rst = 1'b0;

        frame(3);
        chk("step_x", 32'(x), 32'd203);
        chk("step_y", 32'(y), 32'd203);
        chk("step_ft", 32'(sft), 32'd1);

        frame(7);
        repeat (27) frame(15);
        chk("pre_bounce_x", 32'(x), 32'd615);
        frame(10);
        chk("rbounce_x", 32'(x), 32'd624);
        chk("rbounce_bx", 32'(sbx), 32'd1);
        frame(10);
        chk("after_rbounce_x", 32'(x), 32'd614);

        hold = 1'b1;
        frame(7);
        chk("hold_x", 32'(x), 32'd614);
        chk("hold_ft", 32'(sft), 32'd1);
        chk("hold_bnc", 32'({sbx, sby}), 32'd0);
        hold = 1'b0;
        frame(7);
        chk("release_x", 32'(x), 32'd607);

        // Reset asserted in E+2 discards the update in flight.
        @(negedge clk) vSync = 1'b0; speed = 4'd9;
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("midrst_x", 32'(x), 32'd200);
        chk("midrst_y", 32'(y), 32'd200);
        rst = 1'b0; vSync = 1'b1;
        sbx = 1'b0; sby = 1'b0;
        repeat (4) begin
            @(negedge clk);
            sbx |= bounceX; sby |= bounceY;
        end
        chk("midrst_bnc", 32'({sbx, sby}), 32'd0);

        // Drive y to the bottom, back up to 2, then through the top edge.
        repeat (48) frame(15);
        frame(12);
        chk("pre_top_y", 32'(y), 32'd2);
        frame(5);
        chk("top_y", 32'(y), 32'd0);
        chk("top_by", 32'(sby), 32'd1);
        frame(5);
        chk("after_top_y", 32'(y), 32'd5);

        cnt = 1;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            cnt--;
            if (cnt <= 0) begin
                vSync = ~vSync;
                cnt = vSync ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 4));
            end
            if ($urandom_range(0, 3) == 0) speed = 4'($urandom);
            if ($urandom_range(0, 7) == 0) speed = 4'd0;
            hold = ($urandom_range(0, 4) == 0);
            rst  = ($urandom_range(0, 599) == 0);
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
